// File: rtl/dual_issue_regfile.sv
// Writeback-stage GPR file for the dual-issue pipeline: two retire slots, four
// combinational read ports with same-cycle bypass, and a retired-instruction counter.
module dual_issue_regfile #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned RETIRE_W = 32
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_wb_valid0,
    input  logic                i_wb_we0,
    input  logic [4:0]          i_wb_waddr0,
    input  logic [31:0]         i_wb_wdata0,
    input  logic                i_wb_valid1,
    input  logic                i_wb_we1,
    input  logic [4:0]          i_wb_waddr1,
    input  logic [31:0]         i_wb_wdata1,
    input  logic [4:0]          i_raddr0,
    input  logic [4:0]          i_raddr1,
    input  logic [4:0]          i_raddr2,
    input  logic [4:0]          i_raddr3,
    output logic [31:0]         o_rdata0,
    output logic [31:0]         o_rdata1,
    output logic [31:0]         o_rdata2,
    output logic [31:0]         o_rdata3,
    output logic [RETIRE_W-1:0] o_retired_count,
    output logic                o_wb_conflict
);

    logic [31:0]         r_regs [0:NUM_REGS-1];
    logic [RETIRE_W-1:0] r_retired;
    logic                r_conflict;

    logic                w_we0;
    logic                w_we1;
    logic [4:0]          w_raddr [0:3];
    logic [31:0]         w_rdata [0:3];

    // Reset gating here also disables the read bypass while reset is asserted.
    assign w_we0 = i_rst_n & i_wb_valid0 & i_wb_we0 & (i_wb_waddr0 != 5'd0);
    assign w_we1 = i_rst_n & i_wb_valid1 & i_wb_we1 & (i_wb_waddr1 != 5'd0);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_retired  <= '0;
            r_conflict <= 1'b0;
        end else begin
            // Slot 1 is younger: its assignment comes last so it wins a same-address pair.
            if (w_we0) r_regs[i_wb_waddr0] <= i_wb_wdata0;
            if (w_we1) r_regs[i_wb_waddr1] <= i_wb_wdata1;
            r_retired  <= r_retired + RETIRE_W'(i_wb_valid0) + RETIRE_W'(i_wb_valid1);
            r_conflict <= w_we0 & w_we1 & (i_wb_waddr0 == i_wb_waddr1);
        end
    end

    assign w_raddr[0] = i_raddr0;
    assign w_raddr[1] = i_raddr1;
    assign w_raddr[2] = i_raddr2;
    assign w_raddr[3] = i_raddr3;

    always_comb begin
        for (int p = 0; p < 4; p++) begin
            w_rdata[p] = r_regs[w_raddr[p]];
            if (w_raddr[p] == 5'd0) begin
                w_rdata[p] = '0;
            end else if (w_we1 && (w_raddr[p] == i_wb_waddr1)) begin
                w_rdata[p] = i_wb_wdata1;
            end else if (w_we0 && (w_raddr[p] == i_wb_waddr0)) begin
                w_rdata[p] = i_wb_wdata0;
            end
        end
    end

    assign o_rdata0        = w_rdata[0];
    assign o_rdata1        = w_rdata[1];
    assign o_rdata2        = w_rdata[2];
    assign o_rdata3        = w_rdata[3];
    assign o_retired_count = r_retired;
    assign o_wb_conflict   = r_conflict;

endmodule
